// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a small prefetch FIFO.
// Issues one word read per cycle while there is room for the reply, captures
// the reply one cycle later, and presents the oldest fetched instruction
// (plus its PC+1) to the IF/ID register. A redirect from EX/MEM flushes
// everything and restarts fetch at the new target.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  input  logic          stall,
  output logic          imem_req,
  output logic [15:0]   imem_addr,
  input  logic [15:0]   imem_rdata,
  output logic [15:0]   inst_out,
  output logic [15:0]   pc_added_out,
  output logic          inst_valid,
  output logic [CW-1:0] fill_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth and increment constants at the exact widths they are combined with
  localparam logic [CW:0]   LP_DEPTH   = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);

  // Fetch-side state: next address to request and the outstanding request
  logic [15:0]   r_fetchPc;
  logic          r_inflight;
  logic [15:0]   r_inflightAddr;

  // Queue storage: instruction word and the PC+1 that travels with it
  logic [15:0]   r_instMem [DEPTH];
  logic [15:0]   r_pcMem   [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_notEmpty;

  // Issue / push / pop decisions; a pop this cycle never frees a slot for issue
  always_comb begin
    w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_notEmpty  = (r_count != '0);
    w_issue     = !rst && !redirect && (w_occupancy < LP_DEPTH);
    w_push      = r_inflight && !redirect;
    w_pop       = w_notEmpty && !stall && !redirect;
  end

  // Outputs read the registered head entry; zeros whenever the queue is empty
  always_comb begin
    imem_req     = w_issue;
    imem_addr    = r_fetchPc;
    inst_valid   = w_notEmpty;
    fill_count   = r_count;
    inst_out     = w_notEmpty ? r_instMem[r_head] : 16'h0000;
    pc_added_out = w_notEmpty ? r_pcMem[r_head]   : 16'h0000;
  end

  // Fetch address sequencing and tracking of the single outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc      <= 16'h0000;
      r_inflight     <= 1'b0;
      r_inflightAddr <= 16'h0000;
    end else if (redirect) begin
      r_fetchPc      <= redirect_pc;
      r_inflight     <= 1'b0;
    end else if (w_issue) begin
      r_inflight     <= 1'b1;
      r_inflightAddr <= r_fetchPc;
      r_fetchPc      <= r_fetchPc + 16'd1;
    end else begin
      r_inflight     <= 1'b0;
    end
  end

  // Queue pointers and occupancy; redirect flushes without popping or pushing
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the memory reply at the tail; contents need no reset since the
  // outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_instMem[r_tail] <= imem_rdata;
      r_pcMem[r_tail]   <= r_inflightAddr + 16'd1;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus randomized stall/redirect traffic,
// checked every cycle against a queue-based reference model of the fetch unit.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [15:0]   redirect_pc = 16'h0000;
  logic          stall = 1'b0;
  logic          imem_req;
  logic [15:0]   imem_addr;
  logic [15:0]   imem_rdata = 16'h0000;
  logic [15:0]   inst_out;
  logic [15:0]   pc_added_out;
  logic          inst_valid;
  logic [CW-1:0] fill_count;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Reference model: list of {instruction, pc+1}, oldest first
  logic [31:0] mQ[$];
  logic [15:0] mFetchPc = 16'h0000;
  bit          mInflight = 1'b0;
  logic [15:0] mInflightAddr = 16'h0000;

  ifetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .inst_out     (inst_out),
    .pc_added_out (pc_added_out),
    .inst_valid   (inst_valid),
    .fill_count   (fill_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Instruction memory contents: word k holds 16'h1000 + k
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Inputs change at the falling edge so they are stable at the next rising edge
  task automatic applyStimulus(input logic r, input logic rd, input logic [15:0] pc, input logic st);
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = pc;
    stall       = st;
  endtask

  task automatic runCycles(input int n, input logic st);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, st);
  endtask

  // Advance the model at each rising edge, then drive the memory reply
  always @(posedge clk) begin : modelProc
    bit          issued;
    logic [15:0] issuedAddr;
    logic [31:0] entry;
    issued     = !rst && !redirect && ((mQ.size() + int'(mInflight)) < DEPTH);
    issuedAddr = mFetchPc;
    if (rst) begin
      mQ.delete();
      mInflight     = 1'b0;
      mInflightAddr = 16'h0000;
      mFetchPc      = 16'h0000;
      checking      = 1'b1;
    end else if (redirect) begin
      mQ.delete();
      mInflight = 1'b0;
      mFetchPc  = redirect_pc;
    end else begin
      entry = {imem_rdata, mInflightAddr + 16'd1};
      if (mQ.size() > 0 && !stall) void'(mQ.pop_front());
      if (mInflight) mQ.push_back(entry);
      if (issued) begin
        mInflight     = 1'b1;
        mInflightAddr = mFetchPc;
        mFetchPc      = mFetchPc + 16'd1;
      end else begin
        mInflight = 1'b0;
      end
    end
    #1;
    imem_rdata = issued ? memWord(issuedAddr) : 16'($urandom);
  end

  // Compare every output against the model in the middle of each cycle
  always @(negedge clk) begin : compareProc
    bit          expValid;
    bit          expReq;
    logic [15:0] expInst;
    logic [15:0] expPc;
    #2;
    if (checking) begin
      expValid = (mQ.size() != 0);
      expInst  = expValid ? mQ[0][31:16] : 16'h0000;
      expPc    = expValid ? mQ[0][15:0]  : 16'h0000;
      expReq   = !rst && !redirect && ((mQ.size() + int'(mInflight)) < DEPTH);
      checkOutput("inst_valid",   16'(inst_valid),   16'(expValid));
      checkOutput("inst_out",     inst_out,          expInst);
      checkOutput("pc_added_out", pc_added_out,      expPc);
      checkOutput("fill_count",   16'(fill_count),   16'(mQ.size()));
      checkOutput("imem_req",     16'(imem_req),     16'(expReq));
      checkOutput("imem_addr",    imem_addr,         mFetchPc);
    end
  end

  // Run-time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    $display("[TB] ifetch_queue bench start");

    // Reset / cold start
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("rst inst_valid", 16'(inst_valid), 16'h0000);
    checkOutput("rst fill_count", 16'(fill_count), 16'h0000);
    checkOutput("rst inst_out", inst_out, 16'h0000);
    checkOutput("rst pc_added_out", pc_added_out, 16'h0000);
    checkOutput("rst imem_req", 16'(imem_req), 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("cold req0", 16'(imem_req), 16'h0001);
    checkOutput("cold addr0", imem_addr, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("cold addr1", imem_addr, 16'h0001);
    checkOutput("cold not yet valid", 16'(inst_valid), 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("cold first valid", 16'(inst_valid), 16'h0001);
    checkOutput("cold first inst", inst_out, 16'h1000);
    checkOutput("cold first pc", pc_added_out, 16'h0001);
    runCycles(4, 1'b0);
    #3;
    checkOutput("stream fill_count", 16'(fill_count), 16'h0001);

    // Stall fill
    runCycles(8, 1'b1);
    #3;
    checkOutput("stall full count", 16'(fill_count), 16'h0004);
    checkOutput("stall full no req", 16'(imem_req), 16'h0000);
    runCycles(6, 1'b0);

    // Redirect with a request in flight
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    #3;
    checkOutput("redir pre count", 16'(fill_count), 16'h0002);
    checkOutput("redir no req", 16'(imem_req), 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("redir flushed valid", 16'(inst_valid), 16'h0000);
    checkOutput("redir flushed count", 16'(fill_count), 16'h0000);
    checkOutput("redir target addr", imem_addr, 16'h0040);
    checkOutput("redir target req", 16'(imem_req), 16'h0001);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("redir first valid", 16'(inst_valid), 16'h0001);
    checkOutput("redir first inst", inst_out, 16'h1040);
    checkOutput("redir first pc", pc_added_out, 16'h0041);
    runCycles(4, 1'b0);

    // Redirect while stalled with a full queue
    runCycles(8, 1'b1);
    #3;
    checkOutput("stall2 full count", 16'(fill_count), 16'h0004);
    applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1);
    runCycles(8, 1'b1);
    #3;
    checkOutput("refill count", 16'(fill_count), 16'h0004);
    checkOutput("refill head inst", inst_out, 16'h1010);
    checkOutput("refill head pc", pc_added_out, 16'h0011);
    checkOutput("refill no req", 16'(imem_req), 16'h0000);
    runCycles(3, 1'b0);

    // Address wrap-around
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("wrap addr FFFE", imem_addr, 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("wrap addr FFFF", imem_addr, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("wrap addr 0000", imem_addr, 16'h0000);
    checkOutput("wrap inst FFFE", inst_out, 16'h0FFE);
    checkOutput("wrap pc FFFF", pc_added_out, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("wrap pc 0000", pc_added_out, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("wrap pc 0001", pc_added_out, 16'h0001);

    // Randomized stall and occasional redirect
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom_range(0, 99) < 4), 16'($urandom), ($urandom_range(0, 99) < 40));
    end

    // Reset mid-stream with three queued and one in flight
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
    runCycles(2, 1'b0);
    runCycles(2, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("midrst pre count", 16'(fill_count), 16'h0003);
    checkOutput("midrst pre head", inst_out, 16'h1100);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    checkOutput("midrst valid", 16'(inst_valid), 16'h0000);
    checkOutput("midrst count", 16'(fill_count), 16'h0000);
    checkOutput("midrst inst", inst_out, 16'h0000);
    checkOutput("midrst pc", pc_added_out, 16'h0000);
    checkOutput("midrst addr", imem_addr, 16'h0000);
    checkOutput("midrst req", 16'(imem_req), 16'h0001);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, ($urandom_range(0, 99) < 30));
    end

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
